reg_sequencer: RTL and testbench

Fetch/decode/execute control sequencer for the 8-bit datapath. It sits directly upstream of the 16 x 8-bit register block. It fetches 16-bit instructions over a ready handshake, drives the register block's two read ids, and computes an 8-bit result with its internal ALU. It writes the result back through the register block's write_id/write_value pair, where write_id = 0 means "no write" because reg 0 discards writes.

---
 rtl/reg_sequencer_if.sv | 31 +++
 rtl/reg_sequencer.sv | 153 +++++++++++++++
 tb/tb_reg_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_sequencer_if.sv
// reg_sequencer_if -- bus bundle between the sequencer and its neighbours.
//   imem_req/imem_addr    : fetch request and address (sequencer drives)
//   imem_ready/imem_data  : fetch acknowledge and instruction word (memory drives)
//   read1_id/read2_id     : register block read selects (sequencer drives)
//   read1_value/read2_value : combinational read data (register block drives)
//   write_id/write_value  : register block write port, write_id = 0 means idle
// Modports: master = sequencer side, slave = memory / register block side.
interface reg_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic [15:0]         imem_data;
    logic [3:0]          read1_id;
    logic [7:0]          read1_value;
    logic [3:0]          read2_id;
    logic [7:0]          read2_value;
    logic [3:0]          write_id;
    logic [7:0]          write_value;

    modport master (
        output imem_req, imem_addr, read1_id, read2_id, write_id, write_value,
        input  imem_ready, imem_data, read1_value, read2_value
    );

    modport slave (
        input  imem_req, imem_addr, read1_id, read2_id, write_id, write_value,
        output imem_ready, imem_data, read1_value, read2_value
    );
endinterface

// File: rtl/reg_sequencer.sv
// reg_sequencer -- fetch/decode/execute sequencer for the 8-bit datapath.
// Fetches 16-bit instructions, reads up to two registers, runs a small ALU
// and writes the result back into the 16 x 8-bit register block.
// Ports:
//   clock   : single clock, rising edge
//   reset   : synchronous, active-high
//   bus     : reg_sequencer_if.master (instruction fetch + register block)
//   pc      : current program counter
//   halted  : high once a HALT instruction has executed
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_FETCH   | request imem[pc], wait for imem_ready, latch instruction
// S_DECODE  | drive read ids, latch read values as operands
// S_EXECUTE | drive write port for one cycle, update pc
// S_HALT    | stopped, only reset leaves this state
module reg_sequencer #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    reg_sequencer_if.master     bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [15:0]         ir_q;
    logic [7:0]          op_a_q;
    logic [7:0]          op_b_q;

    logic [3:0]          opcode;
    logic [3:0]          rd;
    logic [3:0]          rs1;
    logic [3:0]          rs2;
    logic [7:0]          imm8;

    logic [3:0]          rd1_sel;
    logic [3:0]          rd2_sel;
    logic [7:0]          result;
    logic                writes_rd;
    logic                write_en;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] pc_next;

    assign opcode = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign rs1    = ir_q[7:4];
    assign rs2    = ir_q[3:0];
    assign imm8   = ir_q[7:0];

    assign branch_target = PC_WIDTH'(imm8);

    always_comb begin
        rd1_sel = 4'd0;
        rd2_sel = 4'd0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                rd1_sel = rs1;
                rd2_sel = rs2;
            end
            OP_ADDI, OP_BEQZ: rd1_sel = rd;
            default: ;
        endcase
    end

    always_comb begin
        result    = 8'd0;
        writes_rd = 1'b1;
        case (opcode)
            OP_ADD:  result = op_a_q + op_b_q;
            OP_SUB:  result = op_a_q - op_b_q;
            OP_AND:  result = op_a_q & op_b_q;
            OP_OR:   result = op_a_q | op_b_q;
            OP_XOR:  result = op_a_q ^ op_b_q;
            OP_LDI:  result = imm8;
            OP_ADDI: result = op_a_q + imm8;
            default: writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = pc_q + PC_WIDTH'(1);
        if (opcode == OP_JMP || (opcode == OP_BEQZ && op_a_q == 8'd0)) begin
            pc_next = branch_target;
        end
    end

    // Outputs decode registered state only, but are forced to their reset
    // values while reset is high so a write in flight is squashed in the
    // very cycle reset is asserted.
    assign write_en = !reset && state_q == S_EXECUTE && writes_rd && rd != 4'd0;

    assign bus.imem_req    = !reset && state_q == S_FETCH;
    assign bus.imem_addr   = bus.imem_req ? pc_q : '0;
    assign bus.read1_id    = (!reset && (state_q == S_DECODE || state_q == S_EXECUTE)) ? rd1_sel : 4'd0;
    assign bus.read2_id    = (!reset && (state_q == S_DECODE || state_q == S_EXECUTE)) ? rd2_sel : 4'd0;
    assign bus.write_id    = write_en ? rd : 4'd0;
    assign bus.write_value = write_en ? result : 8'd0;
    assign pc              = reset ? '0 : pc_q;
    assign halted          = !reset && state_q == S_HALT;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= 16'd0;
            op_a_q  <= 8'd0;
            op_b_q  <= 8'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        ir_q    <= bus.imem_data;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a_q  <= bus.read1_value;
                    op_b_q  <= bus.read2_value;
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (opcode == OP_HALT) begin
                        state_q <= S_HALT;
                    end else begin
                        pc_q    <= pc_next;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_sequencer.sv
module tb_reg_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ready_en = 1'b1;
    logic       rf_clear = 1'b1;
    logic [7:0] pc;
    logic       halted;

    logic [15:0] imem [256];
    logic [7:0]  rf [16];

    int n_cmp = 0;
    int n_bad = 0;

    reg_sequencer_if #(.PC_WIDTH(8)) bus ();

    assign bus.imem_ready  = ready_en;
    assign bus.imem_data   = imem[bus.imem_addr];
    assign bus.read1_value = rf[bus.read1_id];
    assign bus.read2_value = rf[bus.read2_id];

    reg_sequencer #(.PC_WIDTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clock = ~clock;

    // register block: reg 0 discards writes
    always @(posedge clock) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'd0;
        end else if (bus.write_id != 4'd0) begin
            rf[bus.write_id] <= bus.write_value;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    // leaves the bench in cycle 1 (first cycle with reset low)
    task automatic do_reset();
        reset    = 1'b1;
        rf_clear = 1'b1;
        ticks(2);
        reset    = 1'b0;
        rf_clear = 1'b0;
        #1;
    endtask

    initial begin
        // ---- LDI r3,0x55 basic timing and reset values
        clear_imem();
        imem[0] = 16'h6355;
        ready_en = 1'b1;
        reset    = 1'b1;
        rf_clear = 1'b1;
        ticks(2);
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_write_id", 32'(bus.write_id), 32'd0);
        check("rst_write_value", 32'(bus.write_value), 32'd0);
        check("rst_read_ids", {24'd0, bus.read1_id, bus.read2_id}, 32'd0);
        reset    = 1'b0;
        rf_clear = 1'b0;
        #1;
        check("c1_imem_req", 32'(bus.imem_req), 32'd1);
        check("c1_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("c1_write_id", 32'(bus.write_id), 32'd0);
        tick();
        check("c2_write_id", 32'(bus.write_id), 32'd0);
        check("c2_imem_req", 32'(bus.imem_req), 32'd0);
        tick();
        check("c3_write_id", 32'(bus.write_id), 32'd3);
        check("c3_write_value", 32'(bus.write_value), 32'h55);
        check("c3_pc", 32'(pc), 32'd0);
        tick();
        check("c4_write_id", 32'(bus.write_id), 32'd0);
        check("c4_pc", 32'(pc), 32'd1);
        check("c4_imem_addr", 32'(bus.imem_addr), 32'd1);

        // ---- ADD wrap and SUB
        clear_imem();
        imem[0] = 16'h61F0;
        imem[1] = 16'h6220;
        imem[2] = 16'h1412;
        imem[3] = 16'h2521;
        imem[4] = 16'hF000;
        do_reset();
        ticks(7);
        check("add_read1_id", 32'(bus.read1_id), 32'd1);
        check("add_read2_id", 32'(bus.read2_id), 32'd2);
        tick();
        check("add_write_id", 32'(bus.write_id), 32'd4);
        check("add_write_value", 32'(bus.write_value), 32'h10);
        ticks(3);
        check("sub_write_id", 32'(bus.write_id), 32'd5);
        check("sub_write_value", 32'(bus.write_value), 32'h30);
        ticks(4);
        check("alu_halted", 32'(halted), 32'd1);
        check("alu_halt_pc", 32'(pc), 32'd4);
        check("alu_rf_r4", 32'(rf[4]), 32'h10);
        check("alu_rf_r5", 32'(rf[5]), 32'h30);

        // ---- fetch stall of 4 cycles
        clear_imem();
        imem[0] = 16'h6355;
        ready_en = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("stall_imem_req", 32'(bus.imem_req), 32'd1);
            check("stall_imem_addr", 32'(bus.imem_addr), 32'd0);
            tick();
        end
        ready_en = 1'b1;
        #1;
        check("stall_c5_imem_req", 32'(bus.imem_req), 32'd1);
        tick();
        check("stall_c6_write_id", 32'(bus.write_id), 32'd0);
        tick();
        check("stall_c7_write_id", 32'(bus.write_id), 32'd3);
        check("stall_c7_write_value", 32'(bus.write_value), 32'h55);

        // ---- write to r0 dropped, BEQZ taken / not taken
        clear_imem();
        imem[8'h00] = 16'h6077;
        imem[8'h01] = 16'h8040;
        imem[8'h40] = 16'h6301;
        imem[8'h41] = 16'h8310;
        imem[8'h42] = 16'hF000;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("r0_write_id", 32'(bus.write_id), 32'd0);
            tick();
        end
        tick();
        check("beqz0_read1_id", 32'(bus.read1_id), 32'd0);
        ticks(2);
        check("beqz_taken_addr", 32'(bus.imem_addr), 32'h40);
        check("beqz_taken_pc", 32'(pc), 32'h40);
        ticks(4);
        check("beqz3_read1_id", 32'(bus.read1_id), 32'd3);
        check("beqz3_read2_id", 32'(bus.read2_id), 32'd0);
        ticks(2);
        check("beqz_not_taken_pc", 32'(pc), 32'h42);

        // ---- JMP 0xFF, NOP wraps pc, then HALT
        clear_imem();
        imem[8'h00] = 16'h81FD;
        imem[8'hFD] = 16'h6101;
        imem[8'hFE] = 16'h90FF;
        imem[8'hFF] = 16'h0000;
        imem[8'h01] = 16'hF000;
        do_reset();
        ticks(3);
        check("jmp_fetch_fd", 32'(bus.imem_addr), 32'hFD);
        ticks(6);
        check("jmp_fetch_ff", 32'(bus.imem_addr), 32'hFF);
        ticks(3);
        check("wrap_pc", 32'(pc), 32'h00);
        check("wrap_imem_addr", 32'(bus.imem_addr), 32'h00);
        check("wrap_imem_req", 32'(bus.imem_req), 32'd1);
        ticks(6);
        for (int i = 0; i < 10; i++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_imem_req", 32'(bus.imem_req), 32'd0);
            check("halt_pc", 32'(pc), 32'h01);
            check("halt_write_id", 32'(bus.write_id), 32'd0);
            tick();
        end

        // ---- reset during EXECUTE of ADD r4
        clear_imem();
        imem[0] = 16'h61F0;
        imem[1] = 16'h6220;
        imem[2] = 16'h1412;
        imem[3] = 16'h2521;
        imem[4] = 16'hF000;
        do_reset();
        ticks(8);
        reset = 1'b1;
        #1;
        check("rexec_write_id", 32'(bus.write_id), 32'd0);
        check("rexec_pc", 32'(pc), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rexec_after_pc", 32'(pc), 32'd0);
        check("rexec_after_halted", 32'(halted), 32'd0);
        check("rexec_after_imem_req", 32'(bus.imem_req), 32'd1);
        check("rexec_after_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rexec_rf_r4", 32'(rf[4]), 32'h00);
        ticks(2);
        check("rexec_refetch_write_id", 32'(bus.write_id), 32'd1);
        check("rexec_refetch_write_value", 32'(bus.write_value), 32'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
